// File: rtl/bp_me_prefetch_dma_arbiter.sv
// Arbitrates cache demand packets and page-filtered prefetches onto one DMA channel,
// tagging reads in order so fills can be attributed. Define BP_ME_PREFETCH_ARB_STATS_EN for issue/drop counters.
module bp_me_prefetch_dma_arbiter #(
  parameter int daddr_width_p       = 28,
  parameter int page_offset_width_p = 12,
  parameter int max_outstanding_p   = 4,
  parameter int stale_limit_p       = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [daddr_width_p-1:0] demand_addr_i,
  input  logic                     demand_write_i,
  input  logic                     demand_v_i,
  output logic                     demand_ready_and_o,
  input  logic [daddr_width_p-1:0] pf_addr_i,
  input  logic                     pf_v_i,
  output logic                     pf_yumi_o,
  output logic [daddr_width_p-1:0] dma_addr_o,
  output logic                     dma_write_o,
  output logic                     dma_v_o,
  input  logic                     dma_ready_and_i,
  input  logic                     fill_done_i,
  output logic                     fill_is_pf_o,
  output logic                     pf_drop_o,
  output logic                     pf_issued_o
`ifdef BP_ME_PREFETCH_ARB_STATS_EN
  ,
  output logic [31:0]              pf_issued_cnt_o,
  output logic [31:0]              pf_drop_cnt_o
`endif
);

  localparam int cnt_w  = $clog2(max_outstanding_p + 1);
  localparam int ptr_w  = $clog2(max_outstanding_p);
  localparam int wait_w = $clog2(stale_limit_p + 1);
  localparam int page_w = daddr_width_p - page_offset_width_p;
  localparam logic [cnt_w-1:0]  max_cnt  = cnt_w'(max_outstanding_p);
  localparam logic [cnt_w-1:0]  pf_cap   = cnt_w'(max_outstanding_p - 1);
  localparam logic [ptr_w-1:0]  last_ptr = ptr_w'(max_outstanding_p - 1);
  localparam logic [wait_w-1:0] stale_lim = wait_w'(stale_limit_p);

  typedef enum logic [1:0] {e_idle, e_demand, e_prefetch} state_e;

  state_e                   state_r, state_n;
  logic [daddr_width_p-1:0] addr_r;
  logic                     write_r;
  logic [page_w-1:0]        page_r;
  logic                     page_v_r;
  logic [wait_w-1:0]        wait_r;
  logic [cnt_w-1:0]         reads_out_r;
  logic [ptr_w-1:0]         rd_ptr_r, wr_ptr_r;
  logic [max_outstanding_p-1:0] tags_r;

  logic demand_grant, pf_grant, pf_drop, page_match, pf_stale;
  logic hs, rd_push, fill_pop;

  assign page_match = page_v_r && (pf_addr_i[daddr_width_p-1:page_offset_width_p] == page_r);
  assign pf_stale   = (wait_r >= stale_lim);

  always_comb begin
    state_n      = state_r;
    demand_grant = 1'b0;
    pf_grant     = 1'b0;
    pf_drop      = 1'b0;
    unique case (state_r)
      e_idle: if (!reset_i) begin
        if (demand_v_i && (demand_write_i || reads_out_r < max_cnt)) begin
          demand_grant = 1'b1;
          state_n      = e_demand;
        end else if (pf_v_i) begin
          if (!page_match || pf_stale) pf_drop = 1'b1;
          // last credit is held back so a demand read can never be starved by prefetches
          else if (reads_out_r < pf_cap) begin
            pf_grant = 1'b1;
            state_n  = e_prefetch;
          end
        end
      end
      e_demand, e_prefetch: if (dma_ready_and_i) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  assign demand_ready_and_o = demand_grant;
  assign pf_yumi_o          = pf_grant | pf_drop;
  assign pf_drop_o          = pf_drop;
  assign dma_v_o            = (state_r != e_idle);
  assign dma_addr_o         = addr_r;
  assign dma_write_o        = write_r;
  assign hs                 = dma_v_o & dma_ready_and_i;
  assign rd_push            = hs & ~write_r;
  assign fill_pop           = fill_done_i & (reads_out_r != '0);
  assign pf_issued_o        = hs & (state_r == e_prefetch);
  assign fill_is_pf_o       = (reads_out_r != '0) & tags_r[rd_ptr_r];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      addr_r   <= '0;
      write_r  <= 1'b0;
      page_r   <= '0;
      page_v_r <= 1'b0;
      wait_r   <= '0;
    end else begin
      state_r <= state_n;
      if (demand_grant) begin
        addr_r  <= demand_addr_i;
        write_r <= demand_write_i;
        if (!demand_write_i) begin
          page_r   <= demand_addr_i[daddr_width_p-1:page_offset_width_p];
          page_v_r <= 1'b1;
        end
      end else if (pf_grant) begin
        addr_r  <= pf_addr_i;
        write_r <= 1'b0;
      end
      if (pf_yumi_o)                 wait_r <= '0;
      else if (pf_v_i && !pf_stale)  wait_r <= wait_r + 1'b1;
    end
  end

  // in-order read tags; occupancy doubles as the outstanding-read count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reads_out_r <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      tags_r      <= '0;
    end else begin
      if (rd_push) begin
        tags_r[wr_ptr_r] <= (state_r == e_prefetch);
        wr_ptr_r         <= (wr_ptr_r == last_ptr) ? '0 : wr_ptr_r + 1'b1;
      end
      if (fill_pop) rd_ptr_r <= (rd_ptr_r == last_ptr) ? '0 : rd_ptr_r + 1'b1;
      case ({rd_push, fill_pop})
        2'b10:   reads_out_r <= reads_out_r + 1'b1;
        2'b01:   reads_out_r <= reads_out_r - 1'b1;
        default: reads_out_r <= reads_out_r;
      endcase
    end
  end

`ifdef BP_ME_PREFETCH_ARB_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pf_issued_cnt_o <= '0;
      pf_drop_cnt_o   <= '0;
    end else begin
      if (pf_issued_o && pf_issued_cnt_o != '1) pf_issued_cnt_o <= pf_issued_cnt_o + 1'b1;
      if (pf_drop_o && pf_drop_cnt_o != '1)     pf_drop_cnt_o   <= pf_drop_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/bp_me_prefetch_dma_arbiter.md
BP_ME_PREFETCH_DMA_ARBITER -- requirements
Module: bp_me_prefetch_dma_arbiter

Interface
REQ-001 SHALL have parameter daddr_width_p, default 28, DMA byte-address width.
REQ-002 SHALL have parameter page_offset_width_p, default 12, log2 page size for the prefetch page filter.
REQ-003 SHALL have parameter max_outstanding_p, default 4, maximum in-flight DMA reads (range 2..16).
REQ-004 SHALL have parameter stale_limit_p, default 8, cycles a prefetch may wait before it is dropped.
REQ-005 SHALL have ports clk_i in 1 (single clock) and reset_i in 1 (asynchronous, active-high).
REQ-006 SHALL have ports demand_addr_i in daddr_width_p, demand_write_i in 1, demand_v_i in 1, demand_ready_and_o out 1: the cache miss/evict packet.
REQ-007 SHALL have ports pf_addr_i in daddr_width_p, pf_v_i in 1, pf_yumi_o out 1: the prefetch request-generator head.
REQ-008 SHALL have ports dma_addr_o out daddr_width_p, dma_write_o out 1, dma_v_o out 1, dma_ready_and_i in 1: the shared DMA packet channel.
REQ-009 SHALL have ports fill_done_i in 1 (last fill beat of a read) and fill_is_pf_o out 1 (combinational tag of the read completing).
REQ-010 SHALL have ports pf_drop_o out 1 (one-cycle pulse) and pf_issued_o out 1 (one-cycle pulse).

Function
REQ-011 SHALL use FSM states e_idle, e_demand, e_prefetch; dma_v_o is 1 exactly in e_demand/e_prefetch.
REQ-012 SHALL, in e_idle, grant demand when demand_v_i & (write | reads_out < max_outstanding_p), latching addr/write, asserting demand_ready_and_o that cycle, and moving to e_demand.
REQ-013 SHALL, in e_idle without a demand grant, grant prefetch when pf_v_i & page match & reads_out < max_outstanding_p-1 (one credit reserved for demand), pulsing pf_yumi_o, latching addr, moving to e_prefetch.
REQ-014 SHALL hold dma_addr_o/dma_write_o stable while dma_v_o=1 until dma_ready_and_i=1, then return to e_idle next cycle; a granted prefetch is never retracted.
REQ-015 SHALL define page match as pf_addr_i[daddr_width_p-1:page_offset_width_p] equal to the page of the last issued demand read; no match before the first demand read.
REQ-016 SHALL pop and pulse pf_drop_o (with pf_yumi_o) for a valid prefetch that fails page match, or whose wait counter reaches stale_limit_p, only in e_idle with no demand grant.
REQ-017 SHALL count prefetch wait cycles while pf_v_i=1 and not popped; clear on pop.
REQ-018 SHALL push a tag (1=prefetch) into an in-order FIFO of max_outstanding_p entries on each read handshake; writes are not tracked.
REQ-019 SHALL pop the tag FIFO on fill_done_i; fill_is_pf_o = head tag, 0 when empty; fill_done_i with empty FIFO ignored.
REQ-020 SHALL keep reads_out unchanged when a read handshake and fill_done_i coincide.
REQ-021 SHALL pulse pf_issued_o on the prefetch handshake cycle.

Reset
REQ-022 SHALL on reset_i asynchronously enter e_idle, clear tag FIFO, reads_out, wait counter, page-valid flag, stats counters; all outputs 0.
REQ-023 SHALL abandon an in-progress packet on reset mid-operation; fills arriving afterward are ignored per REQ-019.

Configuration
REQ-024 SHALL, with BP_ME_PREFETCH_ARB_STATS_EN defined, add outputs pf_issued_cnt_o and pf_drop_cnt_o, 32-bit saturating counters of REQ-021/REQ-016 pulses.
REQ-025 SHALL, without BP_ME_PREFETCH_ARB_STATS_EN, omit those ports and counters, with identical other behaviour.

Verification
REQ-026 SHALL cover: demand read 0x1000 and prefetch 0x1040 both valid in e_idle -> demand issued first, prefetch next grant.
REQ-027 SHALL cover: demand read 0x1000 issued, then prefetch 0x2000 -> pf_drop_o=1 and pf_yumi_o=1 same cycle, no DMA packet.
REQ-028 SHALL cover: 3 reads outstanding (max 4), prefetch valid -> no prefetch grant; demand read 0x1080 -> granted.
REQ-029 SHALL cover: dma_ready_and_i held 0 for 5 cycles -> dma_addr_o constant, dma_v_o=1 throughout.
REQ-030 SHALL cover: demand blocks prefetch 8 cycles -> pf_drop_o pulses; fill_done_i after demand then prefetch reads -> fill_is_pf_o 0 then 1.
REQ-031 SHALL cover: reset_i asserted in e_prefetch -> outputs 0 immediately; later fill_done_i -> fill_is_pf_o=0.
